// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the execute-stage blocks.
package riscv_pkg;
   localparam int XLEN = 32;
endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake between the execute stage (master) and div_ctrl (slave).
interface div_ctrl_if #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [XLEN-1:0]  req_a;
   logic [XLEN-1:0]  req_b;
   logic [TAG_W-1:0] req_tag;
   logic             resp_valid;
   logic             resp_ready;
   logic [XLEN-1:0]  resp_data;
   logic [TAG_W-1:0] resp_tag;

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_tag
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
      output req_ready, resp_valid, resp_data, resp_tag
   );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer between execute and the iterative divider; resolves special cases and absorbs flushes.
// Optional DIV_REM_FUSE_EN adds a last-result cache so a DIV/REM pair shares one divide.
//   state  | meaning
//   IDLE   | ready for a request
//   FAST   | special case or cache hit, result formed without the divider
//   LAUNCH | waiting for divider idle to pulse div_start
//   WAIT   | divider running, waiting for div_done
//   DRAIN  | flushed while divider running, discard its result
//   RESP   | response presented, waiting for resp_ready
module div_ctrl
   import riscv_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   div_ctrl_if.slave       bus,
   input  logic            flush,
   output logic            busy,
   output logic            div_start,
   output logic            div_is_signed,
   output logic            div_is_rem,
   output logic [XLEN-1:0] div_dividend,
   output logic [XLEN-1:0] div_divisor,
   input  logic [XLEN-1:0] div_result,
   input  logic [XLEN-1:0] div_remainder,
   input  logic            div_done,
   input  logic            div_busy
);
   typedef enum logic [2:0] {S_IDLE, S_FAST, S_LAUNCH, S_WAIT, S_DRAIN, S_RESP} state_t;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  resp_data_q, resp_data_d;
   logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

   logic             accept, req_zero, req_ovf, req_hit;
   logic [XLEN-1:0]  fast_data;

`ifdef DIV_REM_FUSE_EN
   logic             c_valid_q, c_valid_d, c_signed_q, c_signed_d;
   logic [XLEN-1:0]  c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
   assign req_hit = c_valid_q && (bus.req_a == c_a_q) && (bus.req_b == c_b_q)
                    && (~bus.req_op[0] == c_signed_q);
`else
   assign req_hit = 1'b0;
`endif

   assign bus.req_ready  = (state_q == S_IDLE) && !flush && !reset;
   assign bus.resp_valid = (state_q == S_RESP) && !flush;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_tag   = resp_tag_q;
   assign busy           = (state_q != S_IDLE);
   assign div_is_signed  = ~op_q[0];
   assign div_is_rem     = op_q[1];
   assign div_dividend   = a_q;
   assign div_divisor    = b_q;

   assign accept   = bus.req_valid && bus.req_ready;
   assign req_zero = (bus.req_b == '0);
   assign req_ovf  = ~bus.req_op[0] && (bus.req_a == INT_MIN) && (bus.req_b == '1);

   // FAST re-derives its result from the captured operands; anything not special was a cache hit.
   always_comb begin
      fast_data = '0;
      if (b_q == '0)
         fast_data = op_q[1] ? a_q : '1;
      else if (~op_q[0] && (a_q == INT_MIN) && (b_q == '1))
         fast_data = op_q[1] ? '0 : a_q;
`ifdef DIV_REM_FUSE_EN
      else
         fast_data = op_q[1] ? c_rem_q : c_quo_q;
`endif
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      resp_data_d = resp_data_q;
      resp_tag_d  = resp_tag_q;
      div_start   = 1'b0;
`ifdef DIV_REM_FUSE_EN
      c_valid_d   = c_valid_q;
      c_signed_d  = c_signed_q;
      c_a_d       = c_a_q;
      c_b_d       = c_b_q;
      c_quo_d     = c_quo_q;
      c_rem_d     = c_rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = bus.req_op;
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               tag_d   = bus.req_tag;
               state_d = (req_zero || req_ovf || req_hit) ? S_FAST : S_LAUNCH;
            end
         end
         S_FAST: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               resp_data_d = fast_data;
               resp_tag_d  = tag_q;
               state_d     = S_RESP;
            end
         end
         S_LAUNCH: begin
            div_start = !div_busy;
            if (flush)
               state_d = div_start ? S_DRAIN : S_IDLE;
            else if (div_start)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush) begin
               state_d = div_done ? S_IDLE : S_DRAIN;
            end else if (div_done) begin
               resp_data_d = op_q[1] ? div_remainder : div_result;
               resp_tag_d  = tag_q;
               state_d     = S_RESP;
`ifdef DIV_REM_FUSE_EN
               c_valid_d   = 1'b1;
               c_signed_d  = ~op_q[0];
               c_a_d       = a_q;
               c_b_d       = b_q;
               c_quo_d     = div_result;
               c_rem_d     = div_remainder;
`endif
            end
         end
         S_DRAIN: begin
            if (div_done)
               state_d = S_IDLE;
         end
         S_RESP: begin
            if (flush || bus.resp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         resp_data_q <= '0;
         resp_tag_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         resp_data_q <= resp_data_d;
         resp_tag_q  <= resp_tag_d;
      end
   end

`ifdef DIV_REM_FUSE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         c_valid_q  <= 1'b0;
         c_signed_q <= 1'b0;
         c_a_q      <= '0;
         c_b_q      <= '0;
         c_quo_q    <= '0;
         c_rem_q    <= '0;
      end else begin
         c_valid_q  <= c_valid_d;
         c_signed_q <= c_signed_d;
         c_a_q      <= c_a_d;
         c_b_q      <= c_b_d;
         c_quo_q    <= c_quo_d;
         c_rem_q    <= c_rem_d;
      end
   end
`endif
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural fixed-latency divider on the far side.
module tb_div_ctrl;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam int DIV_LAT = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic busy, div_start, div_is_signed, div_is_rem;
   logic [XLEN-1:0] div_dividend, div_divisor, div_result, div_remainder;
   logic div_done, div_busy;

   div_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   div_ctrl #(.TAG_W(TAG_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus.slave),
      .flush         (flush),
      .busy          (busy),
      .div_start     (div_start),
      .div_is_signed (div_is_signed),
      .div_is_rem    (div_is_rem),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_result    (div_result),
      .div_remainder (div_remainder),
      .div_done      (div_done),
      .div_busy      (div_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   always @(posedge clk)
      if (!reset && div_start) start_cnt++;

   int dcnt;
   logic [XLEN-1:0] q_pend, r_pend;
   always @(posedge clk) begin
      if (reset) begin
         dcnt <= 0; div_busy <= 1'b0; div_done <= 1'b0;
         div_result <= '0; div_remainder <= '0; q_pend <= '0; r_pend <= '0;
      end else begin
         div_done <= 1'b0;
         if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
               div_done <= 1'b1; div_busy <= 1'b0;
               div_result <= q_pend; div_remainder <= r_pend;
            end
         end else if (div_start) begin
            div_busy <= 1'b1;
            dcnt <= DIV_LAT;
            if (div_divisor == '0) begin
               q_pend <= '1; r_pend <= div_dividend;
            end else if (div_is_signed) begin
               q_pend <= $signed(div_dividend) / $signed(div_divisor);
               r_pend <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
               q_pend <= div_dividend / div_divisor;
               r_pend <= div_dividend % div_divisor;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns on the falling edge just after the accepting rising edge.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("req_ready_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic [31:0] data, output logic [4:0] tag, output int cyc);
      cyc = 1;
      while (!bus.resp_valid && cyc < 100) begin @(negedge clk); cyc++; end
      if (cyc >= 100) chk("resp_timeout", 32'd0, 32'd1);
      data = bus.resp_data;
      tag  = bus.resp_tag;
   endtask

   task automatic consume();
      @(negedge clk);
      chk("resp_valid_after_hs", {31'd0, bus.resp_valid}, 32'd0);
   endtask

   logic [31:0] d;
   logic [4:0]  t;
   int cyc, s0, n;
   logic bad;

   initial begin
      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
      bus.resp_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_busy",       {31'd0, busy},           32'd0);
      chk("rst_div_start",  {31'd0, div_start},      32'd0);
      chk("rst_resp_data",  bus.resp_data,           32'd0);
      chk("rst_resp_tag",   {27'd0, bus.resp_tag},   32'd0);
      chk("rst_dividend",   div_dividend,            32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // DIVU then REMU on the same operands
      s0 = start_cnt;
      send(2'b01, 32'd100, 32'd7, 5'd1);
      wait_resp(d, t, cyc);
      chk("divu_100_7", d, 32'd14);
      chk("divu_tag", {27'd0, t}, 32'd1);
      chk("divu_starts", start_cnt - s0, 32'd1);
      consume();
      s0 = start_cnt;
      send(2'b11, 32'd100, 32'd7, 5'd2);
      wait_resp(d, t, cyc);
      chk("remu_100_7", d, 32'd2);
`ifdef DIV_REM_FUSE_EN
      chk("remu_starts", start_cnt - s0, 32'd0);
`else
      chk("remu_starts", start_cnt - s0, 32'd1);
`endif
      consume();

      // signed overflow
      s0 = start_cnt;
      send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
      wait_resp(d, t, cyc);
      chk("ovf_div", d, 32'h8000_0000);
      chk("ovf_div_lat", cyc, 32'd2);
      consume();
      send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      wait_resp(d, t, cyc);
      chk("ovf_rem", d, 32'd0);
      chk("ovf_rem_lat", cyc, 32'd2);
      chk("ovf_starts", start_cnt - s0, 32'd0);
      consume();

      // divide by zero
      s0 = start_cnt;
      send(2'b01, 32'd9, 32'd0, 5'd5);
      wait_resp(d, t, cyc);
      chk("dz_divu", d, 32'hFFFF_FFFF);
      chk("dz_divu_lat", cyc, 32'd2);
      consume();
      send(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd6);
      wait_resp(d, t, cyc);
      chk("dz_rem", d, 32'hFFFF_FFFB);
      chk("dz_starts", start_cnt - s0, 32'd0);
      consume();

      // back-pressure: resp_ready low for 5 cycles
      bus.resp_ready = 1'b0;
      send(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd7);
      wait_resp(d, t, cyc);
      for (int i = 1; i <= 5; i++) begin
         chk("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
         chk("stall_data", bus.resp_data, 32'hFFFF_FFFA);
         chk("stall_tag", {27'd0, bus.resp_tag}, 32'd7);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      chk("stall_valid6", {31'd0, bus.resp_valid}, 32'd1);
      consume();

      // flush while divider running
      send(2'b01, 32'd77, 32'd3, 5'd8);
      chk("flush_start", {31'd0, div_start}, 32'd1);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("drain_busy", {31'd0, busy}, 32'd1);
      bad = 1'b0;
      n = 0;
      while (!div_done && n < 50) begin
         if (bus.resp_valid || bus.req_ready) bad = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("drain_done_timeout", 32'd0, 32'd1);
      chk("drain_quiet", {31'd0, bad}, 32'd0);
      chk("drain_ready_at_done", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      chk("drain_ready_after", {31'd0, bus.req_ready}, 32'd1);
      chk("drain_no_resp", {31'd0, bus.resp_valid}, 32'd0);

      send(2'b01, 32'd50, 32'd5, 5'd9);
      wait_resp(d, t, cyc);
      chk("post_flush_divu", d, 32'd10);
      chk("post_flush_tag", {27'd0, t}, 32'd9);
      consume();

      // DIV then REM on the same signed operands
      s0 = start_cnt;
      send(2'b00, 32'd1000, 32'd33, 5'd10);
      wait_resp(d, t, cyc);
      chk("fuse_div", d, 32'd30);
      consume();
      send(2'b10, 32'd1000, 32'd33, 5'd11);
      wait_resp(d, t, cyc);
      chk("fuse_rem", d, 32'd10);
`ifdef DIV_REM_FUSE_EN
      chk("fuse_rem_lat", cyc, 32'd2);
      chk("fuse_starts", start_cnt - s0, 32'd1);
`else
      chk("fuse_starts", start_cnt - s0, 32'd2);
`endif
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
